// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the three channels of the load/store front-end:
//   request  : reqValid/reqReady handshake plus write, size, unsigned, address
//              and right-aligned store data from the core
//   response : respValid/respReady handshake plus load data and error flag
//   memory   : aligned word address, read/write strobes and data to/from RAM
// Modport slave is the load/store unit; modport master is the core plus RAM
// side that drives requests, accepts responses and supplies read data.
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddress;
    logic [31:0] reqWriteData;

    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respError;

    logic [31:0] memAddress;
    logic        memReadEnable;
    logic        memWriteEnable;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;

    modport slave (
        input  reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        output reqReady,
        output respValid, respData, respError,
        input  respReady,
        output memAddress, memReadEnable, memWriteEnable, memWriteData,
        input  memReadData
    );

    modport master (
        output reqValid, reqWrite, reqSize, reqUnsigned, reqAddress, reqWriteData,
        input  reqReady,
        input  respValid, respData, respError,
        output respReady,
        input  memAddress, memReadEnable, memWriteEnable, memWriteData,
        output memReadData
    );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store front-end for a 32-bit big-endian word RAM (posedge write,
// negedge read). Accepts byte/half/word loads and stores, issues only aligned
// word accesses, performs read-modify-write for sub-word stores and returns
// sign/zero-extended load data. Misaligned or illegal-size requests get an
// error response without any RAM access.
// Ports:
//   clk  - sole clock, all state on posedge
//   rst  - asynchronous active-low reset
//   bus  - mem_access_unit_if.slave (request, response and RAM channels)
// All outputs are driven straight from flops.
// -----------------------------------------------------------------------------
module mem_access_unit (
    input  logic                    clk,
    input  logic                    rst,
    mem_access_unit_if.slave        bus
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Misaligned halves/words and the reserved size code are rejected.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            SIZE_WORD: bad = (off != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Big-endian lane select: offset 0 is the most significant byte.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (off)
            2'b00:   lane_b = word[31:24];
            2'b01:   lane_b = word[23:16];
            2'b10:   lane_b = word[15:8];
            2'b11:   lane_b = word[7:0];
            default: lane_b = 8'h00;
        endcase
        case (off)
            2'b00:   lane_h = word[31:16];
            2'b10:   lane_h = word[15:0];
            default: lane_h = 16'h0000;
        endcase
        case (size)
            SIZE_BYTE: res = {{24{lane_b[7] & ~uns}}, lane_b};
            SIZE_HALF: res = {{16{lane_h[15] & ~uns}}, lane_h};
            SIZE_WORD: res = word;
            default:   res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic [31:0] data);
        logic [31:0] res;
        case (size)
            SIZE_BYTE: begin
                case (off)
                    2'b00:   res = {data[7:0], word[23:0]};
                    2'b01:   res = {word[31:24], data[7:0], word[15:0]};
                    2'b10:   res = {word[31:16], data[7:0], word[7:0]};
                    2'b11:   res = {word[31:8], data[7:0]};
                    default: res = word;
                endcase
            end
            SIZE_HALF: begin
                if (off[1]) begin
                    res = {word[31:16], data[15:0]};
                end else begin
                    res = {data[15:0], word[15:0]};
                end
            end
            SIZE_WORD: res = data;
            default:   res = word;
        endcase
        return res;
    endfunction

    state_t      state_q,      state_d;
    logic [31:0] addr_q,       addr_d;
    logic [1:0]  size_q,       size_d;
    logic        write_q,      write_d;
    logic        unsigned_q,   unsigned_d;
    logic [31:0] wdata_q,      wdata_d;
    logic        req_ready_q,  req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q,  resp_data_d;
    logic        resp_error_q, resp_error_d;
    logic        mem_re_q,     mem_re_d;
    logic        mem_we_q,     mem_we_d;
    logic [31:0] mem_addr_q,   mem_addr_d;
    logic [31:0] mem_wdata_q,  mem_wdata_d;

    assign bus.reqReady       = req_ready_q;
    assign bus.respValid      = resp_valid_q;
    assign bus.respData       = resp_data_q;
    assign bus.respError      = resp_error_q;
    assign bus.memReadEnable  = mem_re_q;
    assign bus.memWriteEnable = mem_we_q;
    assign bus.memAddress     = mem_addr_q;
    assign bus.memWriteData   = mem_wdata_q;

    // Next-state and next-output computation; every output is registered so
    // strobes and response fields appear the cycle after the deciding edge.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.reqValid && req_ready_q) begin
                    addr_d      = bus.reqAddress;
                    size_d      = bus.reqSize;
                    write_d     = bus.reqWrite;
                    unsigned_d  = bus.reqUnsigned;
                    wdata_d     = bus.reqWriteData;
                    req_ready_d = 1'b0;
                    if (is_bad_access(bus.reqSize, bus.reqAddress[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_data_d  = 32'h0000_0000;
                    end else if (bus.reqWrite && (bus.reqSize == SIZE_WORD)) begin
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {bus.reqAddress[31:2], 2'b00};
                        mem_wdata_d = bus.reqWriteData;
                    end else begin
                        state_d    = ST_READ;
                        mem_re_d   = 1'b1;
                        mem_addr_d = {bus.reqAddress[31:2], 2'b00};
                    end
                end else begin
                    // Also raises ready on the first edge after reset release.
                    req_ready_d = 1'b1;
                end
            end
            ST_READ: begin
                // The RAM presents data on the negedge inside this cycle; the
                // merged store word is itself the captured word register.
                if (write_q) begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = store_merge(bus.memReadData, addr_q[1:0], size_q, wdata_q);
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_data_d  = load_extract(bus.memReadData, addr_q[1:0], size_q, unsigned_q);
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_data_d  = 32'h0000_0000;
            end
            ST_RESP: begin
                if (bus.respReady) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_error_d = 1'b0;
                    resp_data_d  = 32'h0000_0000;
                    req_ready_d  = 1'b1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                resp_error_d = 1'b0;
                resp_data_d  = 32'h0000_0000;
                req_ready_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'h0000_0000;
            size_q       <= 2'b00;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0000_0000;
            resp_error_q <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a behavioural big-endian word RAM
// (posedge write, negedge read). Inputs change and outputs are sampled 1 time
// unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic clk;
    logic rst;
    logic ram_init;
    logic [31:0] ram [0:63];
    int total;
    int passed;
    int overlap_cnt;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM write port (posedge) and preload.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h0000_0000;
            ram[4] <= 32'h8899_AABB;
        end else if (bus.memWriteEnable) begin
            ram[bus.memAddress[7:2]] <= bus.memWriteData;
        end
    end

    // RAM read port (negedge).
    always @(negedge clk) begin
        if (bus.memReadEnable) bus.memReadData <= ram[bus.memAddress[7:2]];
    end

    // Count any cycle where both strobes are high.
    initial overlap_cnt = 0;
    always @(negedge clk) begin
        if (bus.memReadEnable === 1'b1 && bus.memWriteEnable === 1'b1) overlap_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data);
        int waited;
        waited = 0;
        while (bus.reqReady !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (waited >= 20) begin
            total++;
            $display("FAIL issue_ready_timeout: reqReady=%b required 1", bus.reqReady);
        end
        bus.reqValid     = 1'b1;
        bus.reqWrite     = wr;
        bus.reqSize      = size;
        bus.reqUnsigned  = uns;
        bus.reqAddress   = addr;
        bus.reqWriteData = data;
        step();
        bus.reqValid     = 1'b0;
        bus.reqWriteData = 32'h0000_0000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ram_init = 1'b1;
        step();
        step();
        ram_init = 1'b0;
        total++; if (bus.reqReady !== 1'b0) $display("FAIL reset_reqReady: got %b required 0", bus.reqReady); else passed++;
        total++; if ({bus.respValid, bus.respError} !== 2'b00) $display("FAIL reset_resp_flags: got %b required 00", {bus.respValid, bus.respError}); else passed++;
        total++; if (bus.respData !== 32'h0) $display("FAIL reset_respData: got %h required 0", bus.respData); else passed++;
        total++; if ({bus.memReadEnable, bus.memWriteEnable} !== 2'b00) $display("FAIL reset_strobes: got %b required 00", {bus.memReadEnable, bus.memWriteEnable}); else passed++;
        total++; if ({bus.memAddress, bus.memWriteData} !== 64'h0) $display("FAIL reset_mem_bus: got %h required 0", {bus.memAddress, bus.memWriteData}); else passed++;
        rst = 1'b1;
        step();
        total++; if (bus.reqReady !== 1'b1) $display("FAIL release_reqReady: got %b required 1", bus.reqReady); else passed++;
    endtask

    task automatic do_load(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                           input logic [31:0] exp, input string name);
        logic [31:0] exp_addr;
        exp_addr = addr & 32'hFFFF_FFFC;
        issue(1'b0, size, uns, addr, 32'h0);
        total++; if ({bus.memReadEnable, bus.memWriteEnable, bus.reqReady} !== 3'b100) $display("FAIL %s_read_phase: re/we/ready=%b required 100", name, {bus.memReadEnable, bus.memWriteEnable, bus.reqReady}); else passed++;
        total++; if (bus.memAddress !== exp_addr) $display("FAIL %s_memAddress: got %h required %h", name, bus.memAddress, exp_addr); else passed++;
        step();
        total++; if ({bus.respValid, bus.respError} !== 2'b10) $display("FAIL %s_resp_flags: got %b required 10", name, {bus.respValid, bus.respError}); else passed++;
        total++; if (bus.respData !== exp) $display("FAIL %s_respData: got %h required %h", name, bus.respData, exp); else passed++;
        step();
        total++; if ({bus.respValid, bus.reqReady} !== 2'b01) $display("FAIL %s_handshake: valid/ready=%b required 01", name, {bus.respValid, bus.reqReady}); else passed++;
    endtask

    task automatic test_loads();
        do_load(2'b00, 1'b0, 32'h11, 32'hFFFF_FF99, "ld_b11_s");
        do_load(2'b00, 1'b1, 32'h10, 32'h0000_0088, "ld_b10_u");
        do_load(2'b00, 1'b0, 32'h13, 32'hFFFF_FFBB, "ld_b13_s");
        do_load(2'b00, 1'b1, 32'h12, 32'h0000_00AA, "ld_b12_u");
        do_load(2'b01, 1'b1, 32'h12, 32'h0000_AABB, "ld_h12_u");
        do_load(2'b01, 1'b0, 32'h12, 32'hFFFF_AABB, "ld_h12_s");
        do_load(2'b01, 1'b0, 32'h10, 32'hFFFF_8899, "ld_h10_s");
        do_load(2'b10, 1'b0, 32'h10, 32'h8899_AABB, "ld_w10");
    endtask

    task automatic test_stores();
        // Half store: READ, WRITE, then response.
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
        total++; if ({bus.memReadEnable, bus.memWriteEnable} !== 2'b10 || bus.memAddress !== 32'h10) $display("FAIL st_h_read: re/we=%b addr=%h required 10 / 00000010", {bus.memReadEnable, bus.memWriteEnable}, bus.memAddress); else passed++;
        step();
        total++; if ({bus.memReadEnable, bus.memWriteEnable, bus.respValid} !== 3'b010) $display("FAIL st_h_write_phase: re/we/valid=%b required 010", {bus.memReadEnable, bus.memWriteEnable, bus.respValid}); else passed++;
        total++; if (bus.memWriteData !== 32'h8899_1234) $display("FAIL st_h_merge: got %h required 88991234", bus.memWriteData); else passed++;
        step();
        total++; if ({bus.respValid, bus.respError, bus.memWriteEnable} !== 3'b100 || bus.respData !== 32'h0) $display("FAIL st_h_resp: valid/err/we=%b data=%h required 100 / 0", {bus.respValid, bus.respError, bus.memWriteEnable}, bus.respData); else passed++;
        step();
        total++; if (ram[4] !== 32'h8899_1234) $display("FAIL st_h_ram: got %h required 88991234", ram[4]); else passed++;
        do_load(2'b10, 1'b0, 32'h10, 32'h8899_1234, "ld_after_st_h");

        // Byte store at the last lane; upper data bits must be ignored.
        issue(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF5A);
        step();
        total++; if (bus.memWriteData !== 32'h8899_125A) $display("FAIL st_b_merge: got %h required 8899125A", bus.memWriteData); else passed++;
        step();
        step();
        total++; if (ram[4] !== 32'h8899_125A) $display("FAIL st_b_ram: got %h required 8899125A", ram[4]); else passed++;

        // Word store skips the read phase.
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF);
        total++; if ({bus.memReadEnable, bus.memWriteEnable} !== 2'b01 || bus.memAddress !== 32'h14 || bus.memWriteData !== 32'hDEAD_BEEF) $display("FAIL st_w_write: re/we=%b addr=%h data=%h required 01 / 00000014 / DEADBEEF", {bus.memReadEnable, bus.memWriteEnable}, bus.memAddress, bus.memWriteData); else passed++;
        step();
        total++; if ({bus.respValid, bus.respError, bus.memWriteEnable} !== 3'b100) $display("FAIL st_w_resp: valid/err/we=%b required 100", {bus.respValid, bus.respError, bus.memWriteEnable}); else passed++;
        step();
        do_load(2'b10, 1'b0, 32'h14, 32'hDEAD_BEEF, "ld_w14");
        do_load(2'b00, 1'b0, 32'h14, 32'hFFFF_FFDE, "ld_b14_s");
    endtask

    task automatic test_errors();
        logic [3:0] sizes [3];
        logic [31:0] addrs [3];
        sizes[0] = 4'b1_10; addrs[0] = 32'h13;   // word store, misaligned
        sizes[1] = 4'b0_01; addrs[1] = 32'h11;   // half load, odd address
        sizes[2] = 4'b0_11; addrs[2] = 32'h10;   // illegal size
        for (int i = 0; i < 3; i++) begin
            issue(sizes[i][2], sizes[i][1:0], 1'b0, addrs[i], 32'hCAFE_F00D);
            total++; if ({bus.respValid, bus.respError, bus.memReadEnable, bus.memWriteEnable} !== 4'b1100) $display("FAIL err%0d_flags: valid/err/re/we=%b required 1100", i, {bus.respValid, bus.respError, bus.memReadEnable, bus.memWriteEnable}); else passed++;
            total++; if (bus.respData !== 32'h0) $display("FAIL err%0d_respData: got %h required 0", i, bus.respData); else passed++;
            step();
            total++; if ({bus.respValid, bus.respError, bus.memReadEnable, bus.memWriteEnable} !== 4'b0000) $display("FAIL err%0d_after: valid/err/re/we=%b required 0000", i, {bus.respValid, bus.respError, bus.memReadEnable, bus.memWriteEnable}); else passed++;
        end
        total++; if (ram[4] !== 32'h8899_125A) $display("FAIL err_ram_unchanged: got %h required 8899125A", ram[4]); else passed++;
    endtask

    task automatic test_backpressure();
        bus.respReady = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        step();
        total++; if (bus.respValid !== 1'b1 || bus.respData !== 32'hDEAD_BEEF) $display("FAIL bp_first: valid=%b data=%h required 1 / DEADBEEF", bus.respValid, bus.respData); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({bus.respValid, bus.reqReady, bus.memReadEnable, bus.memWriteEnable} !== 4'b1000 || bus.respData !== 32'hDEAD_BEEF) $display("FAIL bp_hold%0d: valid/ready/re/we=%b data=%h required 1000 / DEADBEEF", i, {bus.respValid, bus.reqReady, bus.memReadEnable, bus.memWriteEnable}, bus.respData); else passed++;
        end
        bus.respReady = 1'b1;
        step();
        total++; if ({bus.respValid, bus.reqReady} !== 2'b01) $display("FAIL bp_release: valid/ready=%b required 01", {bus.respValid, bus.reqReady}); else passed++;
    endtask

    task automatic test_reset_mid_op();
        // Reset during the read phase of a byte store.
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0077);
        total++; if (bus.memReadEnable !== 1'b1) $display("FAIL rmw_read_entered: re=%b required 1", bus.memReadEnable); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if ({bus.memReadEnable, bus.memWriteEnable, bus.reqReady, bus.respValid} !== 4'b0000 || bus.memAddress !== 32'h0) $display("FAIL rst_read_outputs: re/we/ready/valid=%b addr=%h required 0000 / 0", {bus.memReadEnable, bus.memWriteEnable, bus.reqReady, bus.respValid}, bus.memAddress); else passed++;
        step();
        rst = 1'b1;
        step();
        total++; if ({bus.reqReady, bus.respValid} !== 2'b10) $display("FAIL rst_read_release: ready/valid=%b required 10", {bus.reqReady, bus.respValid}); else passed++;
        total++; if (ram[4] !== 32'h8899_125A) $display("FAIL rst_read_ram: got %h required 8899125A", ram[4]); else passed++;

        // Reset during the write phase, before its committing edge.
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0077);
        step();
        total++; if (bus.memWriteEnable !== 1'b1 || bus.memWriteData !== 32'h7799_125A) $display("FAIL rmw_write_entered: we=%b data=%h required 1 / 7799125A", bus.memWriteEnable, bus.memWriteData); else passed++;
        #2 rst = 1'b0;
        #1;
        total++; if ({bus.memWriteEnable, bus.memWriteData} !== 33'h0) $display("FAIL rst_write_outputs: we=%b data=%h required 0 / 0", bus.memWriteEnable, bus.memWriteData); else passed++;
        step();
        rst = 1'b1;
        step();
        total++; if (ram[4] !== 32'h8899_125A) $display("FAIL rst_write_ram: got %h required 8899125A", ram[4]); else passed++;
        total++; if ({bus.reqReady, bus.respValid} !== 2'b10) $display("FAIL rst_write_release: ready/valid=%b required 10", {bus.reqReady, bus.respValid}); else passed++;
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        step();
        total++; if (bus.respData !== 32'h0000_0088) $display("FAIL b2b_first: got %h required 00000088", bus.respData); else passed++;
        // Present the next request while still in the response state.
        bus.reqValid    = 1'b1;
        bus.reqWrite    = 1'b0;
        bus.reqSize     = 2'b01;
        bus.reqUnsigned = 1'b1;
        bus.reqAddress  = 32'h16;
        step();
        total++; if ({bus.memReadEnable, bus.reqReady, bus.respValid} !== 3'b010) $display("FAIL b2b_idle_gap: re/ready/valid=%b required 010", {bus.memReadEnable, bus.reqReady, bus.respValid}); else passed++;
        step();
        bus.reqValid = 1'b0;
        total++; if (bus.memReadEnable !== 1'b1 || bus.memAddress !== 32'h14) $display("FAIL b2b_second_read: re=%b addr=%h required 1 / 00000014", bus.memReadEnable, bus.memAddress); else passed++;
        step();
        total++; if (bus.respValid !== 1'b1 || bus.respData !== 32'h0000_BEEF) $display("FAIL b2b_second_data: valid=%b data=%h required 1 / 0000BEEF", bus.respValid, bus.respData); else passed++;
        step();
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b0;
        ram_init = 1'b1;
        bus.reqValid     = 1'b0;
        bus.reqWrite     = 1'b0;
        bus.reqSize      = 2'b00;
        bus.reqUnsigned  = 1'b0;
        bus.reqAddress   = 32'h0;
        bus.reqWriteData = 32'h0;
        bus.respReady    = 1'b1;
        bus.memReadData  = 32'h0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        total++; if (overlap_cnt !== 0) $display("FAIL strobe_overlap: got %0d cycles required 0", overlap_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front-end sitting directly upstream of the 32-bit byte-addressed, big-endian word RAM (posedge write, negedge read). It accepts byte/halfword/word load and store requests from the core over a valid/ready handshake, always issues aligned word accesses to the RAM, and performs read-modify-write for sub-word stores. Loads are returned over a valid/ready response channel, with lane extraction and sign/zero extension. Misaligned accesses are rejected with an error response and never touch memory.

## Interface
- No parameters. Data and address widths are fixed at 32 bits.
- clk  in  1  sole clock. All state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- reqUnsigned  in  1  load zero-extends when 1, sign-extends when 0.
- reqAddress  in  32  byte address.
- reqWriteData  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- respValid  out  1  response present.
- respReady  in  1  consumer accepts response.
- respData  out  32  load result. 0 for stores and errors.
- respError  out  1  misaligned or illegal-size request.
- memAddress  out  32  word-aligned byte address to RAM; [1:0] always 00.
- memReadEnable  out  1  RAM read strobe.
- memWriteEnable  out  1  RAM write strobe.
- memWriteData  out  32  full word to RAM.
- memReadData  in  32  RAM read word.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Request capture: address, size, write, unsigned and data are latched on acceptance (reqValid & reqReady). Inputs are ignored otherwise.
- IDLE: reqReady = 1.
  - Error cases go to RESP with respError = 1: half with addr[0] = 1, word with addr[1:0] ≠ 00, or size 11.
  - Word store goes to WRITE.
  - All loads and sub-word stores go to READ.
- READ: memReadEnable = 1, memAddress = {addr[31:2], 2'b00}. At the next posedge memReadData is captured into the internal word register.
  - Loads then go to RESP.
  - Stores then go to WRITE.
- WRITE: memWriteEnable = 1 for exactly one cycle, memAddress aligned as above, memWriteData = merged word. Then go to RESP.
- RESP: respValid = 1. respData and respError are held stable until respReady. On respValid & respReady go to IDLE.
- Lane mapping is big-endian. Byte offset o occupies bits [31-8o : 24-8o]. Half offset 0 is [31:16]; offset 2 is [15:0].
- Load data: the selected lane is placed right-aligned. Upper bits are filled with the lane MSB when reqUnsigned = 0, and with 0 otherwise. Word loads return the word unchanged.
- Store merge: the captured word with only the selected lane(s) replaced by reqWriteData[7:0] or [15:0]. Word stores use reqWriteData directly, with no read phase.
- Exactly one request is outstanding; there is no pipelining.
- reqReady = 0 in READ, WRITE and RESP.

## Timing
- Reset (rst low, asynchronous): state = IDLE.
  - reqReady = 0 while rst is low.
  - respValid = 0, respError = 0, respData = 0.
  - memReadEnable = 0, memWriteEnable = 0, memAddress = 0, memWriteData = 0.
- First cycle after reset release: reqReady = 1.
- Latency is counted from the accept edge k to the first cycle with respValid = 1:
  - error: k+1;
  - word store: k+2 (WRITE in cycle k+1);
  - load: k+2 (READ in cycle k+1, data sampled at edge k+2);
  - sub-word store: k+3 (READ in k+1, WRITE in k+2).
- Each RAM strobe is asserted for one cycle per request. Read and write strobes are never high together.
- Reset mid-operation: all strobes drop immediately. A WRITE interrupted before its posedge performs no RAM write. The request is discarded and no response is issued.
- Backpressure: while respReady = 0 in RESP, all outputs hold and no RAM activity occurs.
- Back-to-back operation: after a response handshake at edge j, a new request can be accepted at edge j+1 at the earliest (IDLE for one cycle).

## Test plan
- Signed byte load: RAM word at 0x10 = 0x8899AABB. Load byte at 0x11 with reqUnsigned = 0 -> respData = 0xFFFFFF99 at cycle k+2, memAddress = 0x10 during READ.
- Unsigned half load at 0x12 -> respData = 0x0000AABB. The same load with reqUnsigned = 0 -> 0xFFFFAABB.
- Half store at 0x12, data 0x00001234 -> READ in k+1, WRITE in k+2 with memWriteData = 0x88991234, respValid at k+3. A subsequent word load at 0x10 returns 0x88991234.
- Misaligned word store at 0x13 -> respError = 1, respData = 0 at k+1, memReadEnable and memWriteEnable never asserted, RAM word unchanged.
- Backpressure: word load with respReady held low for 3 cycles -> respValid and respData stable, reqReady = 0, no RAM strobes. Handshake completes on the 4th cycle.
- Reset mid-RMW: byte store to 0x10 with rst pulsed low during READ -> all outputs take their reset values immediately, no write occurs, RAM word is unchanged, and reqReady = 1 one cycle after release.
